// File: rtl/memory_access_if.sv
// Data-memory bus between the memory-access stage (master) and the memory (slave).
// Latency: none, signal bundle only.
// Backpressure: the master holds req/addr/we/be/wdata until gnt; read data returns with rvalid.
//
// Signals:
//   dmem_req_o, dmem_we_o       request and write enable (master -> slave)
//   dmem_addr_o                 word-aligned byte address (master -> slave)
//   dmem_wdata_o, dmem_be_o     write data and byte enables (master -> slave)
//   dmem_gnt_i                  request accepted this cycle (slave -> master)
//   dmem_rvalid_i, dmem_rdata_i read data valid and data (slave -> master)
interface memory_access_if;
    logic        dmem_req_o;
    logic        dmem_we_o;
    logic [31:0] dmem_addr_o;
    logic [31:0] dmem_wdata_o;
    logic [3:0]  dmem_be_o;
    logic        dmem_gnt_i;
    logic        dmem_rvalid_i;
    logic [31:0] dmem_rdata_i;

    modport master (
        output dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o, dmem_be_o,
        input  dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i
    );

    modport slave (
        input  dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o, dmem_be_o,
        output dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i
    );
endinterface

// File: rtl/memory_access.sv
// Memory-access pipeline stage: passes ALU ops through, runs loads/stores on the dmem bus.
// Latency: 1 cycle for non-memory ops; memory ops complete on the edge of gnt (store) or rvalid (load).
// Backpressure: stall_o holds upstream while an access is outstanding; downstream sees bubbles meanwhile.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   valid_i, sel_rd_i, mem_re_i, mem_we_i, funct3_i, alu_result_i, store_data_i   upstream instruction
//   stall_o                       upstream must hold its inputs while high
//   dmem                          data-memory bus (memory_access_if.master)
//   sel_rd_o, mem_re_o, mem_we_o, alu_result_o, data_o   registered writeback-stage outputs
//   misalign_o                    one-cycle pulse on a misaligned access
// Build option: define MEMORY_ACCESS_MISALIGN_TRAP_EN to trap misaligned halfword/word accesses;
// without it misalign_o is tied 0 and the offending low address bits are ignored.
module memory_access (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   valid_i,
    input  logic [4:0]             sel_rd_i,
    input  logic                   mem_re_i,
    input  logic                   mem_we_i,
    input  logic [2:0]             funct3_i,
    input  logic [31:0]            alu_result_i,
    input  logic [31:0]            store_data_i,
    output logic                   stall_o,
    memory_access_if.master        dmem,
    output logic [4:0]             sel_rd_o,
    output logic                   mem_re_o,
    output logic                   mem_we_o,
    output logic [31:0]            alu_result_o,
    output logic [31:0]            data_o,
    output logic                   misalign_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t      r_state;

    // Holding registers for the outstanding access
    logic [4:0]  r_rd;
    logic        r_we;
    logic [2:0]  r_funct3;
    logic [31:0] r_addr;
    logic [3:0]  r_be;
    logic [31:0] r_wdata;
    logic        r_req;

    // Registered downstream outputs
    logic [4:0]  r_sel_rd;
    logic        r_mem_re;
    logic        r_mem_we;
    logic [31:0] r_alu;
    logic [31:0] r_data;

    logic        w_is_mem;
    logic        w_start;
    logic        w_misalign;
    logic        w_complete;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [31:0] w_load_data;

    // Pick the addressed byte/halfword out of the returned word and extend it.
    function automatic logic [31:0] extract(input logic [2:0]  f3,
                                            input logic [1:0]  lane,
                                            input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{lane, 3'b000} +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  r = {{24{b[7]}}, b};
            3'b100:  r = {24'd0, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b101:  r = {16'd0, h};
            default: r = word;
        endcase
        return r;
    endfunction

    assign w_is_mem = mem_re_i | mem_we_i;

    // Byte enables and lane-replicated write data; funct3[1:0] is the access size.
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = store_data_i;
        case (funct3_i[1:0])
            2'b00: begin
                w_be    = 4'b0001 << alu_result_i[1:0];
                w_wdata = {4{store_data_i[7:0]}};
            end
            2'b01: begin
                w_be    = alu_result_i[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{store_data_i[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = store_data_i;
            end
        endcase
    end

`ifdef MEMORY_ACCESS_MISALIGN_TRAP_EN
    // Halfword needs addr[0]=0; word-sized (incl. undefined sizes) needs addr[1:0]=0.
    assign w_misalign = ((funct3_i[1:0] == 2'b01) && alu_result_i[0]) ||
                        (funct3_i[1] && (alu_result_i[1:0] != 2'b00));
`else
    assign w_misalign = 1'b0;
`endif

    assign w_start     = (r_state == IDLE) && valid_i && w_is_mem && !w_misalign;
    assign w_load_data = extract(r_funct3, r_addr[1:0], dmem.dmem_rdata_i);

    // Stores finish on gnt; loads finish on rvalid, which may coincide with gnt.
    assign w_complete = ((r_state == REQ) && dmem.dmem_gnt_i && (r_we || dmem.dmem_rvalid_i)) ||
                        ((r_state == WAIT) && dmem.dmem_rvalid_i);

    // Combinational so the upstream holds the instruction on the very cycle it is seen.
    assign stall_o = !rst && (w_start || ((r_state != IDLE) && !w_complete));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_rd     <= 5'd0;
            r_we     <= 1'b0;
            r_funct3 <= 3'd0;
            r_addr   <= 32'd0;
            r_be     <= 4'd0;
            r_wdata  <= 32'd0;
            r_req    <= 1'b0;
            r_sel_rd <= 5'd0;
            r_mem_re <= 1'b0;
            r_mem_we <= 1'b0;
            r_alu    <= 32'd0;
            r_data   <= 32'd0;
        end else begin
            // Bubble unless something below completes this cycle
            r_sel_rd <= 5'd0;
            r_mem_re <= 1'b0;
            r_mem_we <= 1'b0;
            r_data   <= 32'd0;
            case (r_state)
                IDLE: begin
                    r_alu <= alu_result_i;
                    if (w_start) begin
                        r_rd     <= sel_rd_i;
                        r_we     <= mem_we_i;
                        r_funct3 <= funct3_i;
                        r_addr   <= alu_result_i;
                        r_be     <= w_be;
                        r_wdata  <= w_wdata;
                        r_req    <= 1'b1;
                        r_state  <= REQ;
                    end else if (valid_i && !w_is_mem) begin
                        r_sel_rd <= sel_rd_i;
                    end
                end
                REQ: begin
                    r_alu <= r_addr;
                    if (dmem.dmem_gnt_i) begin
                        r_req <= 1'b0;
                        if (r_we) begin
                            r_mem_we <= 1'b1;
                            r_state  <= IDLE;
                        end else if (dmem.dmem_rvalid_i) begin
                            r_sel_rd <= r_rd;
                            r_mem_re <= 1'b1;
                            r_data   <= w_load_data;
                            r_state  <= IDLE;
                        end else begin
                            r_state  <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    r_alu <= r_addr;
                    if (dmem.dmem_rvalid_i) begin
                        r_sel_rd <= r_rd;
                        r_mem_re <= 1'b1;
                        r_data   <= w_load_data;
                        r_state  <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef MEMORY_ACCESS_MISALIGN_TRAP_EN
    logic r_misalign;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_misalign <= 1'b0;
        else     r_misalign <= (r_state == IDLE) && valid_i && w_is_mem && w_misalign;
    end
    assign misalign_o = r_misalign;
`else
    assign misalign_o = 1'b0;
`endif

    assign dmem.dmem_req_o   = r_req;
    assign dmem.dmem_we_o    = r_we;
    assign dmem.dmem_addr_o  = {r_addr[31:2], 2'b00};
    assign dmem.dmem_wdata_o = r_wdata;
    assign dmem.dmem_be_o    = r_be;

    assign sel_rd_o     = r_sel_rd;
    assign mem_re_o     = r_mem_re;
    assign mem_we_o     = r_mem_we;
    assign alu_result_o = r_alu;
    assign data_o       = r_data;

endmodule

// File: tb/tb_memory_access.sv
// Bench for memory_access: directed vectors, randomized ops against a byte-array memory model,
// scoreboard queues for writeback outputs and bus requests, reset-abandon scenario.
// Build with MEMORY_ACCESS_MISALIGN_TRAP_EN to exercise the trap variant.
module tb_memory_access;
    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i;
    logic [4:0]  sel_rd_i;
    logic        mem_re_i, mem_we_i;
    logic [2:0]  funct3_i;
    logic [31:0] alu_result_i, store_data_i;
    logic        stall_o;
    logic [4:0]  sel_rd_o;
    logic        mem_re_o, mem_we_o;
    logic [31:0] alu_result_o, data_o;
    logic        misalign_o;

    memory_access_if bus();

    memory_access dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .sel_rd_i(sel_rd_i),
        .mem_re_i(mem_re_i), .mem_we_i(mem_we_i), .funct3_i(funct3_i),
        .alu_result_i(alu_result_i), .store_data_i(store_data_i), .stall_o(stall_o),
        .dmem(bus), .sel_rd_o(sel_rd_o), .mem_re_o(mem_re_o), .mem_we_o(mem_we_o),
        .alu_result_o(alu_result_o), .data_o(data_o), .misalign_o(misalign_o)
    );

    always #5 clk = ~clk;

    typedef struct { logic [4:0] rd; logic re; logic we; logic [31:0] alu; logic [31:0] data; } wb_t;
    typedef struct { logic [31:0] addr; logic we; logic [3:0] be; logic [31:0] wdata; } rq_t;

    wb_t        expq[$];
    rq_t        reqq[$];
    int         misq = 0;
    logic [7:0] ref_mem [256];
    logic [7:0] slv_mem [256];
    int         n_chk = 0, n_pass = 0;
    int         gnt_wait = -1, rv_wait = -1;
    logic [2:0] ld_f3 [8] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b111};
    logic [2:0] st_f3 [3] = '{3'b000, 3'b001, 3'b010};

    task automatic check(input bit ok, input string name, input string got, input string want);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %s, expected %s", name, got, want);
    endtask

    // Reference model: access size in bytes and its byte offset inside the word.
    function automatic int nbytes(input logic [2:0] f3);
        return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    endfunction

    function automatic int offs(input logic [31:0] a, input int n);
        if (n == 1) return int'(a[1:0]);
        if (n == 2) return a[1] ? 2 : 0;
        return 0;
    endfunction

    function automatic bit trapped(input logic [31:0] a, input int n);
`ifdef MEMORY_ACCESS_MISALIGN_TRAP_EN
        return (a % n) != 0;
`else
        return (a == 32'd0) && (n == 0);
`endif
    endfunction

    function automatic logic [31:0] slv_word(input logic [31:0] a);
        int b;
        b = int'(a[7:0]) & 252;
        return {slv_mem[b+3], slv_mem[b+2], slv_mem[b+1], slv_mem[b]};
    endfunction

    // Present one instruction (kind 0 bubble, 1 ALU, 2 load, 3 store), push its expectations,
    // and hold it until accepted. Called just after a falling edge; returns after the next one
    // following acceptance, when the registered result is visible.
    task automatic issue(input int kind, input logic [4:0] rd, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] sd, output int stalls);
        wb_t w; rq_t q; int n, off, base; logic [31:0] v; bit s;
        valid_i = (kind != 0); sel_rd_i = rd; funct3_i = f3; alu_result_i = a; store_data_i = sd;
        mem_re_i = (kind == 2) || (kind == 0 && $urandom_range(0, 1) == 1);
        mem_we_i = (kind == 3);
        n = nbytes(f3); off = offs(a, n); base = int'(a[7:0]) & 252;
        if (kind == 1) begin
            w = '{rd, 1'b0, 1'b0, a, 32'd0};
            expq.push_back(w);
        end else if (kind >= 2) begin
            if (trapped(a, n)) misq++;
            else begin
                q.addr = a & 32'hFFFF_FFFC; q.we = (kind == 3);
                q.be = 4'(((1 << n) - 1) << off);
                for (int j = 0; j < 4; j++) q.wdata[8*j +: 8] = sd[8*(j % n) +: 8];
                reqq.push_back(q);
                if (kind == 3) begin
                    for (int k = 0; k < n; k++) ref_mem[base+off+k] = sd[8*k +: 8];
                    w = '{5'd0, 1'b0, 1'b1, a, 32'd0};
                end else begin
                    v = 32'd0;
                    for (int k = 0; k < n; k++) v = v | (32'(ref_mem[base+off+k]) << (8*k));
                    if (!f3[2] && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8*n)) - 1);
                    w = '{rd, 1'b1, 1'b0, a, v};
                end
                expq.push_back(w);
            end
        end
        stalls = 0;
        for (int c = 0; c < 60; c++) begin
            #3 s = stall_o;
            @(negedge clk);
            if (!s) break;
            stalls++;
            if (c == 59) check(1'b0, "issue_timeout", "stall held 60 cycles", "release");
        end
        valid_i = 1'b0;
    endtask

    // Memory slave: grants after gnt_wait request cycles, returns read data rv_wait cycles after gnt.
    initial begin : slave
        int req_cnt, cur_g, dly, r, b;
        bit pend;
        logic [31:0] pend_addr;
        rq_t q;
        req_cnt = 0; cur_g = -1; pend = 1'b0; dly = 0; pend_addr = 32'd0;
        bus.dmem_gnt_i = 1'b0; bus.dmem_rvalid_i = 1'b0; bus.dmem_rdata_i = 32'd0;
        forever begin
            @(negedge clk);
            bus.dmem_gnt_i = 1'b0; bus.dmem_rvalid_i = 1'b0; bus.dmem_rdata_i = $urandom;
            if (pend) begin
                if (dly == 0) begin
                    bus.dmem_rvalid_i = 1'b1; bus.dmem_rdata_i = slv_word(pend_addr); pend = 1'b0;
                end else dly--;
            end else if (bus.dmem_req_o) begin
                if (cur_g < 0) cur_g = (gnt_wait < 0) ? $urandom_range(0, 3) : gnt_wait;
                if (req_cnt == cur_g) begin
                    bus.dmem_gnt_i = 1'b1; req_cnt = 0; cur_g = -1;
                    if (reqq.size() == 0) check(1'b0, "bus_req", "unexpected request", "none");
                    else begin
                        q = reqq.pop_front();
                        check(bus.dmem_addr_o == q.addr && bus.dmem_we_o == q.we &&
                              (!q.we || (bus.dmem_be_o == q.be && bus.dmem_wdata_o == q.wdata)), "bus_req",
                              $sformatf("addr=%h we=%b be=%b wdata=%h", bus.dmem_addr_o, bus.dmem_we_o, bus.dmem_be_o, bus.dmem_wdata_o),
                              $sformatf("addr=%h we=%b be=%b wdata=%h", q.addr, q.we, q.be, q.wdata));
                    end
                    if (bus.dmem_we_o) begin
                        b = int'(bus.dmem_addr_o[7:0]);
                        for (int j = 0; j < 4; j++)
                            if (bus.dmem_be_o[j]) slv_mem[b+j] = bus.dmem_wdata_o[8*j +: 8];
                    end else begin
                        r = (rv_wait < 0) ? $urandom_range(0, 2) : rv_wait;
                        if (r == 0) begin
                            bus.dmem_rvalid_i = 1'b1; bus.dmem_rdata_i = slv_word(bus.dmem_addr_o);
                        end else begin
                            pend = 1'b1; dly = r - 1; pend_addr = bus.dmem_addr_o;
                        end
                    end
                end else req_cnt++;
            end
        end
    end

    // Monitor: every non-bubble writeback output is popped from the scoreboard and compared.
    initial begin : monitor
        wb_t w;
        forever begin
            @(negedge clk);
            if (!rst && (sel_rd_o != 5'd0 || mem_re_o || mem_we_o)) begin
                if (expq.size() == 0)
                    check(1'b0, "wb", $sformatf("rd=%0d re=%b we=%b", sel_rd_o, mem_re_o, mem_we_o), "bubble");
                else begin
                    w = expq.pop_front();
                    check(sel_rd_o == w.rd && mem_re_o == w.re && mem_we_o == w.we &&
                          alu_result_o == w.alu && data_o == w.data, "wb",
                          $sformatf("rd=%0d re=%b we=%b alu=%h data=%h", sel_rd_o, mem_re_o, mem_we_o, alu_result_o, data_o),
                          $sformatf("rd=%0d re=%b we=%b alu=%h data=%h", w.rd, w.re, w.we, w.alu, w.data));
                end
            end
            if (misalign_o) begin
                check(misq > 0, "misalign_pulse", "pulse", "no pulse");
                if (misq > 0) misq--;
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got time limit, expected completion");
        $fatal(1, "timeout");
    end

    initial begin : main
        int st, kind;
        logic [7:0] bt;
        logic [2:0] f3;
        logic [4:0] rd;
        logic [31:0] a;
        rq_t q;
        for (int i = 0; i < 256; i++) begin
            bt = 8'($urandom); ref_mem[i] = bt; slv_mem[i] = bt;
        end
        rst = 1'b1; valid_i = 1'b0; sel_rd_i = 5'd0; mem_re_i = 1'b0; mem_we_i = 1'b0;
        funct3_i = 3'd0; alu_result_i = 32'd0; store_data_i = 32'd0;
        repeat (2) @(negedge clk);
        check(stall_o == 1'b0 && sel_rd_o == 5'd0 && !mem_re_o && !mem_we_o && alu_result_o == 32'd0 &&
              data_o == 32'd0 && !misalign_o, "reset_out",
              $sformatf("stall=%b rd=%0d re=%b we=%b alu=%h data=%h mis=%b", stall_o, sel_rd_o, mem_re_o, mem_we_o, alu_result_o, data_o, misalign_o),
              "all zero");
        check(!bus.dmem_req_o && !bus.dmem_we_o && bus.dmem_addr_o == 32'd0 && bus.dmem_be_o == 4'd0 &&
              bus.dmem_wdata_o == 32'd0, "reset_bus",
              $sformatf("req=%b we=%b addr=%h be=%b wdata=%h", bus.dmem_req_o, bus.dmem_we_o, bus.dmem_addr_o, bus.dmem_be_o, bus.dmem_wdata_o),
              "all zero");
        rst = 1'b0;
        @(negedge clk);

        // ADD rd=5
        issue(1, 5'd5, 3'b000, 32'h1234, 32'd0, st);
        check(st == 0, "add_stall", $sformatf("%0d", st), "0");
        check(sel_rd_o == 5'd5 && alu_result_o == 32'h1234, "add_out",
              $sformatf("rd=%0d alu=%h", sel_rd_o, alu_result_o), "rd=5 alu=00001234");

        // LB from 0x103, grant after 2 cycles, rvalid one cycle later
        ref_mem[8'h00] = 8'h00;
        slv_mem[8'h00] = 8'h00;
        for (int k = 0; k < 3; k++) begin ref_mem[k] = 8'hFF; slv_mem[k] = 8'hFF; end
        ref_mem[3] = 8'h80; slv_mem[3] = 8'h80;
        gnt_wait = 2; rv_wait = 1;
        issue(2, 5'd3, 3'b000, 32'h103, 32'd0, st);
        check(st == 4, "lb_stall", $sformatf("%0d", st), "4");
        check(data_o == 32'hFFFF_FF80 && sel_rd_o == 5'd3 && mem_re_o, "lb_out",
              $sformatf("data=%h rd=%0d re=%b", data_o, sel_rd_o, mem_re_o), "data=ffffff80 rd=3 re=1");

        // SH to 0x202, immediate grant
        gnt_wait = 0; rv_wait = 0;
        issue(3, 5'd7, 3'b001, 32'h202, 32'hABCD_1234, st);
        check(st == 1, "sh_stall", $sformatf("%0d", st), "1");
        check(mem_we_o && sel_rd_o == 5'd0 && !mem_re_o, "sh_out",
              $sformatf("we=%b rd=%0d re=%b", mem_we_o, sel_rd_o, mem_re_o), "we=1 rd=0 re=0");

        // LHU at 0x10, gnt and rvalid together: no WAIT cycle
        ref_mem[16] = 8'h0D; ref_mem[17] = 8'hF0; slv_mem[16] = 8'h0D; slv_mem[17] = 8'hF0;
        issue(2, 5'd9, 3'b101, 32'h10, 32'd0, st);
        check(st == 1, "lhu_stall", $sformatf("%0d", st), "1");
        check(data_o == 32'h0000_F00D, "lhu_out", $sformatf("%h", data_o), "0000f00d");

        // LW at 0x6
        issue(2, 5'd4, 3'b010, 32'h6, 32'd0, st);
`ifdef MEMORY_ACCESS_MISALIGN_TRAP_EN
        check(st == 0, "lw_mis_stall", $sformatf("%0d", st), "0");
`else
        check(st == 1, "lw_mis_stall", $sformatf("%0d", st), "1");
`endif

        // Randomized mix
        gnt_wait = -1; rv_wait = -1;
        for (int i = 0; i < 400; i++) begin
            kind = $urandom_range(0, 3);
            rd = (kind == 1) ? 5'($urandom_range(1, 31)) : 5'($urandom_range(0, 31));
            f3 = (kind == 3) ? st_f3[$urandom_range(0, 2)] : ld_f3[$urandom_range(0, 7)];
            a = (kind == 1) ? $urandom : (($urandom & 32'hFFFF_FF00) | 32'($urandom_range(0, 255)));
            issue(kind, rd, f3, a, $urandom, st);
        end
        repeat (3) @(negedge clk);

        // Reset while waiting for read data; the late rvalid must be ignored
        gnt_wait = 0; rv_wait = 6;
        q.addr = 32'h40; q.we = 1'b0; q.be = 4'b0001; q.wdata = 32'd0;
        reqq.push_back(q);
        valid_i = 1'b1; mem_re_i = 1'b1; mem_we_i = 1'b0; sel_rd_i = 5'd6; funct3_i = 3'b000;
        alu_result_i = 32'h40;
        @(negedge clk);
        valid_i = 1'b0; mem_re_i = 1'b0;
        @(negedge clk);
        #1 rst = 1'b1;
        #1 check(!stall_o && !bus.dmem_req_o && sel_rd_o == 5'd0 && !mem_re_o && data_o == 32'd0, "reset_in_wait",
                 $sformatf("stall=%b req=%b rd=%0d re=%b data=%h", stall_o, bus.dmem_req_o, sel_rd_o, mem_re_o, data_o),
                 "all zero");
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check(!stall_o && !bus.dmem_req_o && sel_rd_o == 5'd0 && !mem_re_o && data_o == 32'd0, "late_rvalid",
              $sformatf("stall=%b req=%b rd=%0d re=%b data=%h", stall_o, bus.dmem_req_o, sel_rd_o, mem_re_o, data_o),
              "all zero");

        repeat (3) @(negedge clk);
        check(expq.size() == 0 && reqq.size() == 0 && misq == 0, "drain",
              $sformatf("wb=%0d req=%0d mis=%0d", expq.size(), reqq.size(), misq), "0/0/0");
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
